// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_2m
//  Description : Two-master round-robin Wishbone arbiter for the 8-bit
//                register bus. Optional stuck-slave watchdog is built when
//                WB_ARBITER_TIMEOUT_EN is defined (adds to_flag_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_2m #(
   parameter int ADR_W          = 3,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,

   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [7:0]       m0_dat_i,
   output logic [7:0]       m0_dat_o,
   output logic             m0_ack_o,

   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [7:0]       m1_dat_i,
   output logic [7:0]       m1_dat_o,
   output logic             m1_ack_o,

   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [ADR_W-1:0] s_adr_o,
   output logic [7:0]       s_dat_o,
   input  logic [7:0]       s_dat_i,
   input  logic             s_ack_i,

`ifdef WB_ARBITER_TIMEOUT_EN
   output logic             to_flag_o,
`endif
   output logic [1:0]       gnt_o
);

   // State encoding doubles as the one-hot grant vector
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } state_t;

   generate
      if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
         $error("wb_arbiter_2m: TIMEOUT_CYCLES must be in 2..255");
      end
   endgenerate

   logic [1:0]       r_rst_sync;
   logic             w_rst_n;
   state_t           r_state;
   state_t           w_next_state;
   logic             r_last_gnt;
   logic             w_granted;
   logic             w_release;
   logic             w_m_cyc;
   logic             w_m_stb;
   logic             w_m_we;
   logic [ADR_W-1:0] w_m_adr;
   logic [7:0]       w_m_dat;
   logic             w_s_stb;
   logic             w_ack;
   logic [7:0]       w_rdat;
   logic             w_to_hit;
   logic             w_to_block;

   // Assert asynchronously, release two clocks after the pin goes high
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) r_rst_sync <= 2'b00;
      else             r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_granted = (r_state != ST_IDLE);
   assign w_release = ((r_state == ST_GNT0) && !m0_cyc_i) ||
                      ((r_state == ST_GNT1) && !m1_cyc_i);

   always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= 1'b1;
      end else begin
         r_state <= w_next_state;
         if (w_release) r_last_gnt <= (r_state == ST_GNT1);
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) w_next_state = r_last_gnt ? ST_GNT0 : ST_GNT1;
            else if (m0_cyc_i)        w_next_state = ST_GNT0;
            else if (m1_cyc_i)        w_next_state = ST_GNT1;
         end
         ST_GNT0: if (!m0_cyc_i) w_next_state = ST_IDLE;
         ST_GNT1: if (!m1_cyc_i) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_m_cyc = 1'b0;
      w_m_stb = 1'b0;
      w_m_we  = 1'b0;
      w_m_adr = '0;
      w_m_dat = 8'h00;
      case (r_state)
         ST_GNT0: begin
            w_m_cyc = m0_cyc_i;
            w_m_stb = m0_stb_i;
            w_m_we  = m0_we_i;
            w_m_adr = m0_adr_i;
            w_m_dat = m0_dat_i;
         end
         ST_GNT1: begin
            w_m_cyc = m1_cyc_i;
            w_m_stb = m1_stb_i;
            w_m_we  = m1_we_i;
            w_m_adr = m1_adr_i;
            w_m_dat = m1_dat_i;
         end
         default: ;
      endcase
   end

`ifdef WB_ARBITER_TIMEOUT_EN
   localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_to_cnt;
   logic       r_to_block;
   logic       r_to_flag;

   // Counter holds the number of unacked strobe cycles already elapsed
   assign w_to_hit = w_granted && w_m_stb && !s_ack_i && (r_to_cnt == c_to_last);

   always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_to_cnt   <= 8'd0;
         r_to_block <= 1'b0;
         r_to_flag  <= 1'b0;
      end else begin
         if (!w_granted || !w_m_stb || s_ack_i || w_to_hit || w_release)
            r_to_cnt <= 8'd0;
         else
            r_to_cnt <= r_to_cnt + 8'd1;
         r_to_block <= w_to_hit;
         if (w_to_hit) r_to_flag <= 1'b1;
      end
   end

   assign w_to_block = r_to_block;
   assign to_flag_o  = r_to_flag;
`else
   assign w_to_hit   = 1'b0;
   assign w_to_block = 1'b0;
`endif

   assign w_s_stb = w_m_stb && !w_to_hit;
   assign w_ack   = w_to_hit || (s_ack_i && w_s_stb && !w_to_block);
   assign w_rdat  = w_to_hit ? 8'hFF : s_dat_i;

   assign s_cyc_o = w_m_cyc;
   assign s_stb_o = w_s_stb;
   assign s_we_o  = w_m_we;
   assign s_adr_o = w_m_adr;
   assign s_dat_o = w_m_dat;

   assign m0_ack_o = (r_state == ST_GNT0) && w_ack;
   assign m1_ack_o = (r_state == ST_GNT1) && w_ack;
   assign m0_dat_o = (r_state == ST_GNT0) ? w_rdat : 8'h00;
   assign m1_dat_o = (r_state == ST_GNT1) ? w_rdat : 8'h00;

   assign gnt_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter_2m
//  Description : Directed, self-checking bench for wb_arbiter_2m. Timeout
//                checks are compiled in with WB_ARBITER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_2m;

   localparam int ADR_W = 3;

   logic             wb_clk_i = 1'b0;
   logic             wb_rst_n_i;
   logic             m0_cyc_i, m0_stb_i, m0_we_i;
   logic [ADR_W-1:0] m0_adr_i;
   logic [7:0]       m0_dat_i, m0_dat_o;
   logic             m0_ack_o;
   logic             m1_cyc_i, m1_stb_i, m1_we_i;
   logic [ADR_W-1:0] m1_adr_i;
   logic [7:0]       m1_dat_i, m1_dat_o;
   logic             m1_ack_o;
   logic             s_cyc_o, s_stb_o, s_we_o;
   logic [ADR_W-1:0] s_adr_o;
   logic [7:0]       s_dat_o, s_dat_i;
   logic             s_ack_i;
   logic [1:0]       gnt_o;
`ifdef WB_ARBITER_TIMEOUT_EN
   logic             to_flag_o;
`endif

   always #5 wb_clk_i = ~wb_clk_i;

   wb_arbiter_2m #(.ADR_W(ADR_W), .TIMEOUT_CYCLES(15)) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_n_i (wb_rst_n_i),
      .m0_cyc_i   (m0_cyc_i),
      .m0_stb_i   (m0_stb_i),
      .m0_we_i    (m0_we_i),
      .m0_adr_i   (m0_adr_i),
      .m0_dat_i   (m0_dat_i),
      .m0_dat_o   (m0_dat_o),
      .m0_ack_o   (m0_ack_o),
      .m1_cyc_i   (m1_cyc_i),
      .m1_stb_i   (m1_stb_i),
      .m1_we_i    (m1_we_i),
      .m1_adr_i   (m1_adr_i),
      .m1_dat_i   (m1_dat_i),
      .m1_dat_o   (m1_dat_o),
      .m1_ack_o   (m1_ack_o),
      .s_cyc_o    (s_cyc_o),
      .s_stb_o    (s_stb_o),
      .s_we_o     (s_we_o),
      .s_adr_o    (s_adr_o),
      .s_dat_o    (s_dat_o),
      .s_dat_i    (s_dat_i),
      .s_ack_i    (s_ack_i),
`ifdef WB_ARBITER_TIMEOUT_EN
      .to_flag_o  (to_flag_o),
`endif
      .gnt_o      (gnt_o)
   );

   typedef struct {
      logic [2:0]  m0_ctl;   // {cyc, stb, we}
      logic [2:0]  m0_adr;
      logic [7:0]  m0_dat;
      logic [2:0]  m1_ctl;
      logic [2:0]  m1_adr;
      logic [7:0]  m1_dat;
      logic        s_ack;
      logic [7:0]  s_dat;
      logic [33:0] exp;
   } vec_t;

   vec_t vecs[13];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic set_m0(input logic [2:0] ctl, input logic [2:0] adr, input logic [7:0] dat);
      {m0_cyc_i, m0_stb_i, m0_we_i} = ctl;
      m0_adr_i = adr;
      m0_dat_i = dat;
   endtask

   task automatic set_m1(input logic [2:0] ctl, input logic [2:0] adr, input logic [7:0] dat);
      {m1_cyc_i, m1_stb_i, m1_we_i} = ctl;
      m1_adr_i = adr;
      m1_dat_i = dat;
   endtask

   // {gnt, s_cyc/stb/we, s_adr, s_dat, m0_ack, m0_dat, m1_ack, m1_dat}
   function automatic logic [33:0] ex(input logic [1:0] g, input logic [2:0] sctl,
                                      input logic [2:0] sadr, input logic [7:0] sdat,
                                      input logic a0, input logic [7:0] d0,
                                      input logic a1, input logic [7:0] d1);
      return {g, sctl, sadr, sdat, a0, d0, a1, d1};
   endfunction

   function automatic logic [33:0] outs();
      return {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
              m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       d0, d1;
      logic [1:0] prev, owner;
      int         ngr;

      // Single read by m1 with a stray ack while stb is low
      vecs[0]  = '{3'b000, 3'd0, 8'h00, 3'b110, 3'd3, 8'h00, 1'b0, 8'h00, ex(2'b00, 3'b000, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00)};
      vecs[1]  = '{3'b000, 3'd0, 8'h00, 3'b110, 3'd3, 8'h00, 1'b0, 8'h00, ex(2'b10, 3'b110, 3'd3, 8'h00, 0, 8'h00, 0, 8'h00)};
      vecs[2]  = '{3'b000, 3'd0, 8'h00, 3'b110, 3'd3, 8'h00, 1'b1, 8'h2A, ex(2'b10, 3'b110, 3'd3, 8'h00, 0, 8'h00, 1, 8'h2A)};
      vecs[3]  = '{3'b000, 3'd0, 8'h00, 3'b100, 3'd3, 8'h00, 1'b1, 8'h55, ex(2'b10, 3'b100, 3'd3, 8'h00, 0, 8'h00, 0, 8'h55)};
      vecs[4]  = '{3'b000, 3'd0, 8'h00, 3'b000, 3'd0, 8'h00, 1'b0, 8'h00, ex(2'b10, 3'b000, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00)};
      vecs[5]  = '{3'b000, 3'd0, 8'h00, 3'b000, 3'd0, 8'h00, 1'b0, 8'h00, ex(2'b00, 3'b000, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00)};
      // Simultaneous requests, one write each: m0 then m1
      vecs[6]  = '{3'b111, 3'd1, 8'h11, 3'b111, 3'd2, 8'h22, 1'b0, 8'h00, ex(2'b00, 3'b000, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00)};
      vecs[7]  = '{3'b111, 3'd1, 8'h11, 3'b111, 3'd2, 8'h22, 1'b1, 8'h00, ex(2'b01, 3'b111, 3'd1, 8'h11, 1, 8'h00, 0, 8'h00)};
      vecs[8]  = '{3'b000, 3'd0, 8'h00, 3'b111, 3'd2, 8'h22, 1'b0, 8'h00, ex(2'b01, 3'b000, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00)};
      vecs[9]  = '{3'b000, 3'd0, 8'h00, 3'b111, 3'd2, 8'h22, 1'b1, 8'h99, ex(2'b00, 3'b000, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00)};
      vecs[10] = '{3'b000, 3'd0, 8'h00, 3'b111, 3'd2, 8'h22, 1'b1, 8'h00, ex(2'b10, 3'b111, 3'd2, 8'h22, 0, 8'h00, 1, 8'h00)};
      vecs[11] = '{3'b000, 3'd0, 8'h00, 3'b000, 3'd0, 8'h00, 1'b0, 8'h00, ex(2'b10, 3'b000, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00)};
      vecs[12] = '{3'b000, 3'd0, 8'h00, 3'b000, 3'd0, 8'h00, 1'b1, 8'h77, ex(2'b00, 3'b000, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00)};

      wb_rst_n_i = 1'b0;
      set_m0(3'b000, 3'd0, 8'h00);
      set_m1(3'b000, 3'd0, 8'h00);
      s_ack_i = 1'b0;
      s_dat_i = 8'h00;
      step(); step();

      // Held in reset: requests and acks must not propagate
      set_m0(3'b110, 3'd0, 8'h00);
      s_ack_i = 1'b1;
      #1;
      check("rst_outputs", outs(), ex(2'b00, 3'b000, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00));
`ifdef WB_ARBITER_TIMEOUT_EN
      check("rst_to_flag", to_flag_o, 0);
`endif
      step();
      wb_rst_n_i = 1'b1;
      for (int k = 0; k < 8 && gnt_o != 2'b01; k++) step();
      check("rst_release_gnt", gnt_o, 2'b01);
      check("granted_ack", {s_cyc_o, m0_ack_o}, 2'b11);

      // Reset asserted mid-cycle while m0 owns the bus
      #2 wb_rst_n_i = 1'b0;
      #1;
      check("midcycle_rst", {gnt_o, s_cyc_o, m0_ack_o}, 4'b0000);
      step(); step();
      wb_rst_n_i = 1'b1;
      set_m0(3'b000, 3'd0, 8'h00);
      s_ack_i = 1'b0;
      step(); step(); step();
      set_m0(3'b100, 3'd0, 8'h00);
      set_m1(3'b100, 3'd0, 8'h00);
      #1;
      check("post_rst_idle", gnt_o, 2'b00);
      step();
      check("post_rst_tie_m0", gnt_o, 2'b01);
      set_m0(3'b000, 3'd0, 8'h00);
      set_m1(3'b000, 3'd0, 8'h00);
      #1;
      check("drop_both", {gnt_o, s_cyc_o}, 3'b010);
      step();
      check("back_idle", gnt_o, 2'b00);

      for (int i = 0; i < 13; i++) begin
         step();
         set_m0(vecs[i].m0_ctl, vecs[i].m0_adr, vecs[i].m0_dat);
         set_m1(vecs[i].m1_ctl, vecs[i].m1_adr, vecs[i].m1_dat);
         s_ack_i = vecs[i].s_ack;
         s_dat_i = vecs[i].s_dat;
         #1;
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // Burst: m0 keeps cyc over four writes while m1 waits
      set_m0(3'b111, 3'd0, 8'hA0);
      set_m1(3'b110, 3'd5, 8'h00);
      s_ack_i = 1'b1;
      s_dat_i = 8'h00;
      #1;
      check("burst_idle", {gnt_o, m1_ack_o}, 3'b000);
      for (int i = 0; i < 4; i++) begin
         step();
         set_m0(3'b111, 3'(i), 8'hA0 + 8'(i));
         #1;
         check($sformatf("burst_wr%0d", i),
               {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m0_ack_o, m1_ack_o},
               {2'b01, 3'b111, 3'(i), 8'hA0 + 8'(i), 1'b1, 1'b0});
      end
      step();
      set_m0(3'b000, 3'd0, 8'h00);
      #1;
      check("burst_drop", {gnt_o, s_cyc_o, m1_ack_o}, 4'b0100);
      step();
      check("burst_gap", {gnt_o, s_cyc_o, m1_ack_o}, 4'b0000);
      step();
      check("burst_m1", {gnt_o, s_we_o, s_adr_o, m1_ack_o}, {2'b10, 1'b0, 3'd5, 1'b1});
      step();
      set_m1(3'b000, 3'd0, 8'h00);
      step(); step();

      // Continuous contention: each master re-requests one cycle after its ack
      d0 = 1'b0; d1 = 1'b0; prev = 2'b00; owner = 2'b10; ngr = 0;
      for (int c = 0; c < 100 && ngr < 6; c++) begin
         step();
         set_m0({!d0, !d0, 1'b1}, 3'd1, 8'h5A);
         set_m1({!d1, !d1, 1'b1}, 3'd2, 8'hA5);
         #1;
         check("ack_isolation", {m0_ack_o & ~gnt_o[0], m1_ack_o & ~gnt_o[1]}, 2'b00);
         if (gnt_o != 2'b00 && prev == 2'b00) begin
            ngr++;
            check($sformatf("alt_grant%0d", ngr), gnt_o, (owner == 2'b01) ? 2'b10 : 2'b01);
            owner = gnt_o;
         end
         d0 = m0_ack_o;
         d1 = m1_ack_o;
         prev = gnt_o;
      end
      check("alt_grant_count", ngr, 6);
      set_m0(3'b000, 3'd0, 8'h00);
      set_m1(3'b000, 3'd0, 8'h00);
      s_ack_i = 1'b0;
      step(); step(); step();

`ifdef WB_ARBITER_TIMEOUT_EN
      // m0 read to a slave that never acks
      set_m0(3'b110, 3'd4, 8'h00);
      s_dat_i = 8'h00;
      #1;
      check("to_idle", gnt_o, 2'b00);
      for (int k = 1; k <= 15; k++) begin
         step();
         if (k < 15)
            check($sformatf("to_wait%0d", k), {gnt_o, s_stb_o, m0_ack_o, m0_dat_o}, {2'b01, 1'b1, 1'b0, 8'h00});
         else
            check("to_fire", {gnt_o, s_stb_o, m0_ack_o, m0_dat_o}, {2'b01, 1'b0, 1'b1, 8'hFF});
      end
      step();
      s_ack_i = 1'b1;
      s_dat_i = 8'h3C;
      #1;
      check("to_late_ack", {m0_ack_o, to_flag_o}, 2'b01);
      set_m0(3'b000, 3'd0, 8'h00);
      s_ack_i = 1'b0;
      step(); step(); step();
      check("to_flag_sticky", to_flag_o, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
